// File: rtl/keypad_pkg.sv
// Shared keypad types: key coordinates, emulator FSM states and matrix size.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef logic [1:0] kp_idx_t;

  typedef struct packed {
    kp_idx_t row;
    kp_idx_t col;
  } kp_key_t;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESS_BOUNCE   = 3'd1,
    HOLD           = 3'd2,
    RELEASE_BOUNCE = 3'd3,
    GAP            = 3'd4
  } kp_emu_state_t;

  // Round an odd toggle count up so bounce bursts end on the stated level.
  function automatic int unsigned even_up(input int unsigned n);
    return n + (n % 32'd2);
  endfunction

endpackage

// File: rtl/keypad_emulator_sync2.sv
// Four-bit two-flop synchronizer; idles at the released (high) level.
module sync2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  // Two-stage capture of the asynchronous column drive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// Keypad matrix responder: closes one emulated key with bounce, hold and gap
// phases and answers the scanner's column drive on the row pins.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int BOUNCE_EDGES  = 4,
  parameter int BOUNCE_CYCLES = 256,
  parameter int GAP_CYCLES    = 1024,
  parameter int CNT_W         = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       cols,
  output logic [3:0]       rows,
  input  logic             req_valid,
  input  logic [3:0]       req_key,
  input  logic [CNT_W-1:0] req_hold,
  output logic             req_ready,
  output logic             busy,
  output logic             done,
  output logic             contact
);

  localparam int unsigned      EDGES       = even_up(BOUNCE_EDGES);
  localparam bit               NO_BOUNCE   = (EDGES == 0);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EDGE_LOAD   = CNT_W'(EDGES);

  kp_emu_state_t    state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic [CNT_W-1:0] edges, next_edges;
  logic [CNT_W-1:0] hold, next_hold;
  kp_key_t          key, next_key;
  logic [CNT_W-1:0] eff_hold;
  logic             accept;
  logic [3:0]       cols_s;
  logic [3:0]       row_drive;
  logic             next_contact, next_done, next_ready, next_busy;

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cols),
    .q     (cols_s)
  );

  assign accept   = req_valid & req_ready;
  assign eff_hold = (req_hold == CNT_ZERO) ? CNT_ONE : req_hold;

  // State, phase counters and the latched request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= CNT_ZERO;
      edges <= CNT_ZERO;
      hold  <= CNT_ZERO;
      key   <= kp_key_t'(4'h0);
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      edges <= next_edges;
      hold  <= next_hold;
      key   <= next_key;
    end
  end

  // Phase sequencing: each phase loads its counter on entry and leaves at zero.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_edges = edges;
    next_hold  = hold;
    next_key   = key;
    case (state)
      IDLE: begin
        if (accept) begin
          next_key  = kp_key_t'(req_key);
          next_hold = eff_hold;
          if (NO_BOUNCE) begin
            next_state = HOLD;
            next_cnt   = eff_hold - CNT_ONE;
            next_edges = CNT_ZERO;
          end else begin
            next_state = PRESS_BOUNCE;
            next_cnt   = BOUNCE_LOAD;
            next_edges = EDGE_LOAD;
          end
        end else begin
          next_state = IDLE;
        end
      end
      PRESS_BOUNCE: begin
        if (cnt != CNT_ZERO) begin
          next_cnt = cnt - CNT_ONE;
        end else if (edges <= CNT_ONE) begin
          next_state = HOLD;
          next_cnt   = hold - CNT_ONE;
          next_edges = CNT_ZERO;
        end else begin
          next_cnt   = BOUNCE_LOAD;
          next_edges = edges - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt != CNT_ZERO) begin
          next_cnt = cnt - CNT_ONE;
        end else if (NO_BOUNCE) begin
          next_state = GAP;
          next_cnt   = GAP_LOAD;
        end else begin
          next_state = RELEASE_BOUNCE;
          next_cnt   = BOUNCE_LOAD;
          next_edges = EDGE_LOAD;
        end
      end
      RELEASE_BOUNCE: begin
        if (cnt != CNT_ZERO) begin
          next_cnt = cnt - CNT_ONE;
        end else if (edges <= CNT_ONE) begin
          next_state = GAP;
          next_cnt   = GAP_LOAD;
          next_edges = CNT_ZERO;
        end else begin
          next_cnt   = BOUNCE_LOAD;
          next_edges = edges - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt != CNT_ZERO) begin
          next_cnt = cnt - CNT_ONE;
        end else begin
          next_state = IDLE;
          next_cnt   = CNT_ZERO;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = CNT_ZERO;
        next_edges = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the upcoming state; bounce level follows the edge parity.
  always_comb begin
    next_contact = 1'b0;
    next_done    = (next_state == GAP) && (next_cnt == CNT_ZERO);
    next_ready   = (next_state == IDLE);
    next_busy    = (next_state != IDLE);
    case (next_state)
      PRESS_BOUNCE:   next_contact = ~next_edges[0];
      HOLD:           next_contact = 1'b1;
      RELEASE_BOUNCE: next_contact = next_edges[0];
      default:        next_contact = 1'b0;
    endcase
  end

  // Registered handshake and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      contact   <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      contact   <= next_contact;
      done      <= next_done;
      req_ready <= next_ready;
      busy      <= next_busy;
    end
  end

  // Only the latched row may be pulled low, and only while its column is driven.
  always_comb begin
    row_drive = 4'hF;
    for (int r = 0; r < ROWS; r++) begin
      row_drive[r] = ~(contact & (key.row == kp_idx_t'(r)) & ~cols_s[key.col]);
    end
  end

  // Row pin register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows <= 4'hF;
    end else begin
      rows <= row_drive;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: a clean-edge instance and a bouncing one.
module tb_keypad_emulator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  cols = 4'hF;
  logic        req_valid0 = 1'b0;
  logic        req_valid4 = 1'b0;
  logic [3:0]  req_key = 4'h0;
  logic [23:0] req_hold = 24'd0;

  logic [3:0]  rows0, rows4;
  logic        rdy0, busy0, done0, contact0;
  logic        rdy4, busy4, done4, contact4;

  int n_assert = 0;
  int n_fail   = 0;

  // results collected by monitor
  int c_cnt, r_cnt, r_bad, rot_err, done_cnt, done_idx, post_busy, post_rdy;
  int trans[$];

  always #5 clk = ~clk;

  keypad_emulator #(.BOUNCE_EDGES(0), .BOUNCE_CYCLES(256), .GAP_CYCLES(1024), .CNT_W(24)) dut0 (
    .clk(clk), .reset(reset), .cols(cols), .rows(rows0),
    .req_valid(req_valid0), .req_key(req_key), .req_hold(req_hold),
    .req_ready(rdy0), .busy(busy0), .done(done0), .contact(contact0)
  );

  keypad_emulator dut4 (
    .clk(clk), .reset(reset), .cols(cols), .rows(rows4),
    .req_valid(req_valid4), .req_key(req_key), .req_hold(req_hold),
    .req_ready(rdy4), .busy(busy4), .done(done4), .contact(contact4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic request(input bit use4, input logic [3:0] key, input logic [23:0] hold);
    req_key  = key;
    req_hold = hold;
    if (use4) req_valid4 = 1'b1; else req_valid0 = 1'b1;
    tick;
    req_valid0 = 1'b0;
    req_valid4 = 1'b0;
  endtask

  function automatic logic [3:0] rot_cols(input int j);
    logic [3:0] pat [4];
    pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    return pat[((j < 0) ? 0 : j / 8) % 4];
  endfunction

  // Samples from step 0 (just after the accept edge) until one step past done.
  task automatic monitor(input bit use4, input int max_ticks, input logic [3:0] low_pat,
                         input bit rotate, input int hold_cycles, input int pulse_at);
    logic       c, c_prev, d, ec;
    logic [3:0] r, er, cj;
    c_prev = 1'b0;
    c_cnt = 0; r_cnt = 0; r_bad = 0; rot_err = 0;
    done_cnt = 0; done_idx = -1; post_busy = -1; post_rdy = -1;
    trans.delete();
    for (int i = 0; i < max_ticks; i++) begin
      c = use4 ? contact4 : contact0;
      d = use4 ? done4 : done0;
      r = use4 ? rows4 : rows0;
      if (done_idx >= 0) begin
        post_busy = use4 ? int'(busy4) : int'(busy0);
        post_rdy  = use4 ? int'(rdy4) : int'(rdy0);
        break;
      end
      if (c !== c_prev) trans.push_back(i);
      c_prev = c;
      if (c === 1'b1) c_cnt++;
      if (r === low_pat) r_cnt++;
      else if (r !== 4'hF) r_bad++;
      if (d === 1'b1) begin
        done_cnt++;
        done_idx = i;
      end
      if (rotate) begin
        ec = (i - 1 >= 0) && (i - 1 < hold_cycles);
        cj = rot_cols(i - 3);
        er = (ec && !cj[2]) ? 4'b1101 : 4'b1111;
        if (r !== er) rot_err++;
        cols = rot_cols(i);
      end
      if (i == pulse_at) begin
        req_valid0 = 1'b1;
        req_key    = 4'h0;
        req_hold   = 24'd7;
      end else if (i == pulse_at + 1) begin
        req_valid0 = 1'b0;
      end
      tick;
    end
  endtask

  initial begin
    int exp_tr [10];
    exp_tr = '{0, 256, 512, 768, 1024, 6024, 6280, 6536, 6792, 7048};

    // 1: reset held, then released
    #2 reset = 1'b0;
    tick; tick; tick;
    check("rst_rows0", rows0, 4'hF);
    check("rst_rdy0", rdy0, 1'b0);
    check("rst_busy0", busy0, 1'b0);
    check("rst_done0", done0, 1'b0);
    check("rst_contact0", contact0, 1'b0);
    check("rst_rows4", rows4, 4'hF);
    reset = 1'b1;
    tick;
    check("idle_rdy0", rdy0, 1'b1);
    check("idle_rdy4", rdy4, 1'b1);
    check("idle_busy0", busy0, 1'b0);
    check("idle_done0", done0, 1'b0);
    check("idle_rows0", rows0, 4'hF);

    // 2: clean edges, row1/col2, hold 100, col2 driven statically
    cols = 4'b1011;
    tick; tick; tick;
    request(1'b0, 4'b0110, 24'd100);
    check("t2_busy", busy0, 1'b1);
    check("t2_ready", rdy0, 1'b0);
    check("t2_contact0", contact0, 1'b1);
    monitor(1'b0, 1500, 4'b1101, 1'b0, 0, -1);
    check("t2_contact_cycles", c_cnt, 100);
    check("t2_rows_low_cycles", r_cnt, 100);
    check("t2_rows_bad", r_bad, 0);
    check("t2_first_trans", trans.size() > 0 ? trans[0] : -1, 0);
    check("t2_fall_idx", trans.size() > 1 ? trans[1] : -1, 100);
    check("t2_done_idx", done_idx, 1123);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_post_busy", post_busy, 0);
    check("t2_post_ready", post_rdy, 1);

    // 3: same key, columns rotating every 8 clk
    cols = 4'b1110;
    tick; tick; tick;
    request(1'b0, 4'b0110, 24'd100);
    monitor(1'b0, 1500, 4'b1101, 1'b1, 100, -1);
    check("t3_rows_model_err", rot_err, 0);
    check("t3_rows_low_cycles", r_cnt, 24);
    check("t3_rows_bad", r_bad, 0);
    check("t3_done_cnt", done_cnt, 1);

    // 4: bouncing instance, row2/col1, hold 5000
    cols = 4'b1101;
    tick; tick; tick;
    request(1'b1, 4'b1001, 24'd5000);
    monitor(1'b1, 9000, 4'b1011, 1'b0, 0, -1);
    check("t4_trans_count", trans.size(), 10);
    if (trans.size() == 10) begin
      for (int k = 0; k < 10; k++) check($sformatf("t4_trans_%0d", k), trans[k], exp_tr[k]);
    end
    check("t4_contact_cycles", c_cnt, 6024);
    check("t4_rows_low_cycles", r_cnt, 6024);
    check("t4_rows_bad", r_bad, 0);
    check("t4_done_idx", done_idx, 8071);
    check("t4_done_cnt", done_cnt, 1);

    // 5: request during HOLD ignored; then hold 0 acts as 1
    cols = 4'b0111;
    tick; tick; tick;
    request(1'b0, 4'b1111, 24'd50);
    monitor(1'b0, 1500, 4'b0111, 1'b0, 0, 10);
    check("t5_contact_cycles", c_cnt, 50);
    check("t5_rows_low_cycles", r_cnt, 50);
    check("t5_rows_bad", r_bad, 0);
    check("t5_done_idx", done_idx, 1073);
    check("t5_done_cnt", done_cnt, 1);
    check("t5_post_busy", post_busy, 0);
    cols = 4'b1110;
    tick; tick; tick;
    request(1'b0, 4'b0000, 24'd0);
    monitor(1'b0, 1500, 4'b1110, 1'b0, 0, -1);
    check("t5_hold0_contact", c_cnt, 1);
    check("t5_hold0_rows_low", r_cnt, 1);
    check("t5_hold0_done_idx", done_idx, 1024);

    // 6: reset in the middle of HOLD
    cols = 4'b1011;
    tick; tick; tick;
    request(1'b0, 4'b0110, 24'd100);
    for (int k = 0; k < 20; k++) tick;
    check("t6_rows_before", rows0, 4'b1101);
    reset = 1'b0;
    #1;
    check("t6_rows_in_reset", rows0, 4'hF);
    check("t6_busy_in_reset", busy0, 1'b0);
    check("t6_contact_in_reset", contact0, 1'b0);
    tick; tick;
    check("t6_done_in_reset", done0, 1'b0);
    reset = 1'b1;
    tick; tick; tick;
    check("t6_ready_after", rdy0, 1'b1);
    request(1'b0, 4'b0110, 24'd10);
    check("t6_busy_new", busy0, 1'b1);
    monitor(1'b0, 1500, 4'b1101, 1'b0, 0, -1);
    check("t6_contact_cycles", c_cnt, 10);
    check("t6_done_idx", done_idx, 1033);
    check("t6_done_cnt", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
